zl_puncturer: RTL and testbench



---
 rtl/zl_puncturer.sv | 110 +++++++++++
 tb/tb_zl_puncturer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/zl_puncturer.sv
// DVB-S puncturer: deletes mother-code bits per the selected rate and repacks
// the survivors, in transmission order, into I/Q pairs through a 4-bit buffer.
module zl_puncturer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] code_rate,
   input  logic       data_in_i,
   input  logic       data_in_q,
   input  logic       data_in_req,
   output logic       data_in_ack,
   output logic       data_out_i,
   output logic       data_out_q,
   output logic       data_out_req,
   input  logic       data_out_ack
);

   // Period length for each rate; unknown encodings fall back to 1/2.
   function automatic logic [2:0] period_of(input logic [2:0] r);
      case (r)
         3'd1:    period_of = 3'd2;
         3'd2:    period_of = 3'd3;
         3'd3:    period_of = 3'd5;
         3'd4:    period_of = 3'd7;
         default: period_of = 3'd1;
      endcase
   endfunction

   // Returns {keep_x, keep_y} for a rate at a period position.
   function automatic logic [1:0] keep_mask(input logic [2:0] r, input logic [2:0] p);
      keep_mask = 2'b11;
      case (r)
         3'd1: keep_mask = (p == 3'd0) ? 2'b11 : 2'b01;
         3'd2: case (p)
                  3'd0:    keep_mask = 2'b11;
                  3'd1:    keep_mask = 2'b01;
                  default: keep_mask = 2'b10;
               endcase
         3'd3: case (p)
                  3'd0:       keep_mask = 2'b11;
                  3'd1, 3'd3: keep_mask = 2'b01;
                  default:    keep_mask = 2'b10;
               endcase
         3'd4: case (p)
                  3'd0:       keep_mask = 2'b11;
                  3'd4, 3'd6: keep_mask = 2'b10;
                  default:    keep_mask = 2'b01;
               endcase
         default: keep_mask = 2'b11;
      endcase
   endfunction

   logic [3:0] buff, base_buf, next_buf;
   logic [2:0] count, base_cnt, next_cnt;
   logic [2:0] pos, next_pos;
   logic [2:0] active_rate, rate_sel;
   logic [1:0] keep;
   logic       accept, emit;

   assign accept   = data_in_req && data_in_ack;
   assign emit     = data_out_req && data_out_ack;
   assign rate_sel = (pos == 3'd0) ? code_rate : active_rate;
   assign keep     = keep_mask(rate_sel, pos);

   // Bit 0 of the buffer is always the oldest; emission shifts the pair out
   // before new bits land at the first free slot.
   always_comb begin
      base_buf = emit ? {2'b00, buff[3:2]} : buff;
      base_cnt = emit ? count - 3'd2 : count;
      next_buf = base_buf;
      next_cnt = base_cnt;
      next_pos = pos;
      if (accept) begin
         if (keep[1]) begin
            next_buf[next_cnt[1:0]] = data_in_i;
            next_cnt = next_cnt + 3'd1;
         end
         if (keep[0]) begin
            next_buf[next_cnt[1:0]] = data_in_q;
            next_cnt = next_cnt + 3'd1;
         end
         next_pos = (pos == period_of(rate_sel) - 3'd1) ? 3'd0 : pos + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buff         <= '0;
         count        <= '0;
         pos          <= '0;
         active_rate  <= '0;
         data_in_ack  <= 1'b1;
         data_out_req <= 1'b0;
         data_out_i   <= 1'b0;
         data_out_q   <= 1'b0;
      end else begin
         buff         <= next_buf;
         count        <= next_cnt;
         pos          <= next_pos;
         if (accept && pos == 3'd0)
            active_rate <= code_rate;
         // Handshake flags track the registered count, so neither depends on
         // this cycle's req/ack inputs.
         data_in_ack  <= (next_cnt <= 3'd2);
         data_out_req <= (next_cnt >= 3'd2);
         data_out_i   <= next_buf[0];
         data_out_q   <= next_buf[1];
      end
   end

endmodule

// File: tb/tb_zl_puncturer.sv
// Directed scoreboard bench for zl_puncturer: a bit-queue model of the
// puncture tables predicts every output pair.
module tb_zl_puncturer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] code_rate;
   logic       data_in_i, data_in_q, data_in_req, data_in_ack;
   logic       data_out_i, data_out_q, data_out_req, data_out_ack;

   int checks = 0;
   int failures = 0;
   int nout = 0;
   int stalls = 0;
   int n0;

   string xs[5] = '{"1", "10", "101", "10101", "1000101"};
   string ys[5] = '{"1", "11", "110", "11010", "1111010"};
   int mpos = 0;
   int mrate = 0;
   logic bitq[$];
   logic [1:0] expq[$];

   zl_puncturer dut (
      .clk(clk), .rst_n(rst_n), .code_rate(code_rate),
      .data_in_i(data_in_i), .data_in_q(data_in_q),
      .data_in_req(data_in_req), .data_in_ack(data_in_ack),
      .data_out_i(data_out_i), .data_out_q(data_out_q),
      .data_out_req(data_out_req), .data_out_ack(data_out_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic x, input logic y);
      string sx, sy;
      if (mpos == 0) mrate = (code_rate > 3'd4) ? 0 : int'(code_rate);
      sx = xs[mrate];
      sy = ys[mrate];
      if (sx[mpos] == "1") bitq.push_back(x);
      if (sy[mpos] == "1") bitq.push_back(y);
      mpos++;
      if (mpos == sx.len()) mpos = 0;
      while (bitq.size() >= 2) begin
         expq.push_back({bitq[0], bitq[1]});
         void'(bitq.pop_front());
         void'(bitq.pop_front());
      end
   endtask

   // Called just after a rising edge; returns just after the transfer edge.
   task automatic send(input logic x, input logic y);
      int n = 0;
      data_in_req = 1'b1;
      data_in_i = x;
      data_in_q = y;
      forever begin
         @(negedge clk);
         if (data_in_ack) break;
         n++;
         stalls++;
         if (n > 50) break;
      end
      if (n > 50) begin
         chk("in_ack_timeout", data_in_ack, 1);
      end else begin
         model_accept(x, y);
         @(posedge clk);
      end
      #1 data_in_req = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((expq.size() != 0 || data_out_req) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_pending"}, expq.size(), 0);
      chk({tag, "_req_low"}, data_out_req, 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n && data_out_req && data_out_ack) begin
         nout++;
         if (expq.size() == 0) begin
            chk("out_extra", expq.size(), 1);
         end else begin
            e = expq.pop_front();
            chk("out_pair", {data_out_i, data_out_q}, e);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      code_rate = 3'd0;
      data_in_i = 1'b0;
      data_in_q = 1'b0;
      data_in_req = 1'b0;
      data_out_ack = 1'b1;
      #12;
      chk("rst_req", data_out_req, 0);
      chk("rst_i", data_out_i, 0);
      chk("rst_q", data_out_q, 0);
      chk("rst_in_ack", data_in_ack, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // rate 1/2 streaming, plus first-pair latency
      stalls = 0; n0 = nout;
      send(1'b1, 1'b0);
      chk("lat_req", data_out_req, 1);
      chk("lat_pair", {data_out_i, data_out_q}, 2'b10);
      send(1'b0, 1'b1);
      send(1'b1, 1'b1);
      wait_drain("r12");
      chk("r12_nout", nout - n0, 3);
      chk("r12_stalls", stalls, 0);

      // rate 2/3
      code_rate = 3'd1; n0 = nout;
      send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1); send(1'b1, 1'b0);
      wait_drain("r23");
      chk("r23_nout", nout - n0, 3);

      // rate 3/4
      code_rate = 3'd2; n0 = nout;
      send(1'b1, 1'b0); send(1'b0, 1'b1); send(1'b1, 1'b1);
      wait_drain("r34");
      chk("r34_nout", nout - n0, 2);

      // rate 7/8 all-ones at full throughput
      code_rate = 3'd4; n0 = nout; stalls = 0;
      for (int k = 0; k < 7; k++) send(1'b1, 1'b1);
      wait_drain("r78");
      chk("r78_nout", nout - n0, 4);
      chk("r78_stalls", stalls, 0);

      // full buffer with output stalled
      code_rate = 3'd0; data_out_ack = 1'b0; n0 = nout;
      send(1'b1, 1'b0);
      send(1'b0, 1'b1);
      chk("full_in_ack", data_in_ack, 0);
      chk("full_req", data_out_req, 1);
      chk("full_pair", {data_out_i, data_out_q}, 2'b10);
      @(negedge clk);
      chk("full_hold_ack", data_in_ack, 0);
      chk("full_hold_pair", {data_out_i, data_out_q}, 2'b10);
      @(posedge clk);
      #1 data_out_ack = 1'b1;
      @(negedge clk);
      chk("drain_in_ack_low", data_in_ack, 0);
      @(posedge clk);
      #1;
      chk("drain_in_ack_back", data_in_ack, 1);
      chk("drain_req", data_out_req, 1);
      wait_drain("full");
      chk("full_nout", nout - n0, 2);

      // rate change 3/4 -> 1/2 at pos 1 takes effect at next boundary
      code_rate = 3'd2; n0 = nout;
      send(1'b1, 1'b0);
      code_rate = 3'd0;
      send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
      wait_drain("chg");
      chk("chg_nout", nout - n0, 4);

      // invalid rate behaves as 1/2
      code_rate = 3'd7; n0 = nout;
      send(1'b0, 1'b1); send(1'b1, 1'b0);
      wait_drain("inv");
      chk("inv_nout", nout - n0, 2);

      // reset mid-period with count=3
      code_rate = 3'd2; data_out_ack = 1'b0;
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      chk("pre_rst_req", data_out_req, 1);
      chk("pre_rst_in_ack", data_in_ack, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", data_out_req, 0);
      chk("mid_rst_i", data_out_i, 0);
      chk("mid_rst_q", data_out_q, 0);
      chk("mid_rst_in_ack", data_in_ack, 1);
      bitq.delete();
      expq.delete();
      mpos = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      data_out_ack = 1'b1;
      code_rate = 3'd1; n0 = nout;
      send(1'b1, 1'b0); send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b0);
      wait_drain("post_rst");
      chk("post_rst_nout", nout - n0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
